// File: rtl/tile_sequencer.sv
// Tile sequencer: splits an MxN job into WxW tiles, issues one command per
// tile to the control unit in row-major order and waits for all completions.
module tile_sequencer #(
  parameter int unsigned ADDR_WIDTH           = 10,
  parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [7:0]            job_m,
  input  logic [7:0]            job_n,
  input  logic [4:0]            job_k,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [ADDR_WIDTH-1:0] base_c,
  input  logic [ADDR_WIDTH-1:0] base_d,
  input  logic [ADDR_WIDTH-1:0] stride_a,
  input  logic [ADDR_WIDTH-1:0] stride_b,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [63:0]           cmd_data,
  input  logic                  tile_done,
  output logic                  busy,
  output logic                  job_done,
  output logic                  job_error,
  output logic [8:0]            tiles_issued
);

  localparam int unsigned W  = SYSTOLIC_ARRAY_WIDTH;
  localparam int unsigned AF = 10;
  localparam logic [7:0]            W8 = 8'(W);
  localparam logic [5:0]            WK = 6'(W);
  localparam logic [ADDR_WIDTH-1:0] WA = ADDR_WIDTH'(W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_CALC,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t state_q;

  logic                  job_ready_q;
  logic                  cmd_valid_q;
  logic [63:0]           cmd_data_q;
  logic                  busy_q;
  logic                  job_done_q;
  logic                  job_error_q;
  logic [8:0]            tiles_issued_q;
  logic [8:0]            done_cnt_q;

  // Latched job context
  logic [7:0]            tiles_m_q;
  logic [7:0]            tiles_n_q;
  logic [7:0]            last_m_q;
  logic [7:0]            last_n_q;
  logic [8:0]            total_q;
  logic [4:0]            k_q;
  logic [ADDR_WIDTH-1:0] base_b_q;
  logic [ADDR_WIDTH-1:0] base_c_q;
  logic [ADDR_WIDTH-1:0] stride_a_q;
  logic [ADDR_WIDTH-1:0] stride_b_q;

  // Tile indices and running addresses for the current tile
  logic [7:0]            mi_q;
  logic [7:0]            ni_q;
  logic [ADDR_WIDTH-1:0] acc_a_q;
  logic [ADDR_WIDTH-1:0] acc_b_q;
  logic [ADDR_WIDTH-1:0] acc_c_q;
  logic [ADDR_WIDTH-1:0] acc_d_q;

  logic [7:0]  tiles_m_d;
  logic [7:0]  tiles_n_d;
  logic [7:0]  last_m_d;
  logic [7:0]  last_n_d;
  logic [8:0]  total_d;
  logic        last_mi;
  logic        last_ni;
  logic [7:0]  cur_len_m;
  logic [7:0]  cur_len_n;
  logic [63:0] cmd_d;
  logic [8:0]  done_next;
  logic        job_bad;

  // Tile geometry derived from the offered job, captured on acceptance
  always_comb begin
    tiles_m_d = 8'((32'(job_m) + W - 1) / W);
    tiles_n_d = 8'((32'(job_n) + W - 1) / W);
    last_m_d  = ((32'(job_m) % W) == 0) ? W8 : 8'(32'(job_m) % W);
    last_n_d  = ((32'(job_n) % W) == 0) ? W8 : 8'(32'(job_n) % W);
    total_d   = 9'(16'(tiles_m_d) * 16'(tiles_n_d));
  end

  // Current-tile command word and job sanity check
  always_comb begin
    last_mi   = (mi_q == tiles_m_q - 8'd1);
    last_ni   = (ni_q == tiles_n_q - 8'd1);
    cur_len_m = last_mi ? last_m_q : W8;
    cur_len_n = last_ni ? last_n_q : W8;
    cmd_d     = {AF'(acc_d_q), AF'(acc_c_q), AF'(acc_b_q), AF'(acc_a_q),
                 cur_len_n, 8'(k_q), cur_len_m};
    done_next = done_cnt_q + 9'(tile_done);
    job_bad   = (tiles_m_q == 8'd0) || (tiles_n_q == 8'd0) ||
                (k_q == 5'd0) || ({1'b0, k_q} > WK);
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      job_ready_q    <= 1'b1;
      cmd_valid_q    <= 1'b0;
      cmd_data_q     <= '0;
      busy_q         <= 1'b0;
      job_done_q     <= 1'b0;
      job_error_q    <= 1'b0;
      tiles_issued_q <= '0;
      done_cnt_q     <= '0;
      tiles_m_q      <= '0;
      tiles_n_q      <= '0;
      last_m_q       <= '0;
      last_n_q       <= '0;
      total_q        <= '0;
      k_q            <= '0;
      base_b_q       <= '0;
      base_c_q       <= '0;
      stride_a_q     <= '0;
      stride_b_q     <= '0;
      mi_q           <= '0;
      ni_q           <= '0;
      acc_a_q        <= '0;
      acc_b_q        <= '0;
      acc_c_q        <= '0;
      acc_d_q        <= '0;
    end else begin
      job_done_q  <= 1'b0;
      job_error_q <= 1'b0;

      if (tile_done && (state_q inside {S_CALC, S_ISSUE, S_DRAIN})) begin
        done_cnt_q <= done_cnt_q + 9'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (job_valid && job_ready_q) begin
            tiles_m_q      <= tiles_m_d;
            tiles_n_q      <= tiles_n_d;
            last_m_q       <= last_m_d;
            last_n_q       <= last_n_d;
            total_q        <= total_d;
            k_q            <= job_k;
            base_b_q       <= base_b;
            base_c_q       <= base_c;
            stride_a_q     <= stride_a;
            stride_b_q     <= stride_b;
            mi_q           <= '0;
            ni_q           <= '0;
            acc_a_q        <= base_a;
            acc_b_q        <= base_b;
            acc_c_q        <= base_c;
            acc_d_q        <= base_d;
            tiles_issued_q <= '0;
            done_cnt_q     <= '0;
            job_ready_q    <= 1'b0;
            busy_q         <= 1'b1;
            state_q        <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (job_bad) begin
            job_error_q <= 1'b1;
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            state_q <= S_CALC;
          end
        end

        S_CALC: begin
          cmd_data_q  <= cmd_d;
          cmd_valid_q <= 1'b1;
          state_q     <= S_ISSUE;
        end

        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q    <= 1'b0;
            tiles_issued_q <= tiles_issued_q + 9'd1;
            acc_d_q        <= acc_d_q + WA;
            if (last_ni) begin
              ni_q    <= '0;
              acc_b_q <= base_b_q;
              acc_c_q <= base_c_q;
              if (last_mi) begin
                state_q <= S_DRAIN;
              end else begin
                mi_q    <= mi_q + 8'd1;
                acc_a_q <= acc_a_q + stride_a_q;
                state_q <= S_CALC;
              end
            end else begin
              ni_q    <= ni_q + 8'd1;
              acc_b_q <= acc_b_q + stride_b_q;
              acc_c_q <= acc_c_q + WA;
              state_q <= S_CALC;
            end
          end
        end

        S_DRAIN: begin
          if (done_next >= total_q) begin
            job_done_q  <= 1'b1;
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          job_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          cmd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign job_ready    = job_ready_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_data     = cmd_data_q;
  assign busy         = busy_q;
  assign job_done     = job_done_q;
  assign job_error    = job_error_q;
  assign tiles_issued = tiles_issued_q;

endmodule

// File: tb/tb_tile_sequencer.sv
// Directed bench for tile_sequencer: single tile, multi-tile geometry,
// back-pressure, job errors, mid-job reset and stray completions.
module tb_tile_sequencer;

  logic        clk;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [7:0]  job_m;
  logic [7:0]  job_n;
  logic [4:0]  job_k;
  logic [9:0]  base_a;
  logic [9:0]  base_b;
  logic [9:0]  base_c;
  logic [9:0]  base_d;
  logic [9:0]  stride_a;
  logic [9:0]  stride_b;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_data;
  logic        tile_done;
  logic        busy;
  logic        job_done;
  logic        job_error;
  logic [8:0]  tiles_issued;

  int total = 0;
  int bad   = 0;

  tile_sequencer #(
    .ADDR_WIDTH           (10),
    .SYSTOLIC_ARRAY_WIDTH (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_m        (job_m),
    .job_n        (job_n),
    .job_k        (job_k),
    .base_a       (base_a),
    .base_b       (base_b),
    .base_c       (base_c),
    .base_d       (base_d),
    .stride_a     (stride_a),
    .stride_b     (stride_b),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_data     (cmd_data),
    .tile_done    (tile_done),
    .busy         (busy),
    .job_done     (job_done),
    .job_error    (job_error),
    .tiles_issued (tiles_issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [9:0] a, input logic [9:0] b,
                                       input logic [9:0] c, input logic [9:0] d,
                                       input logic [7:0] lm, input logic [7:0] ln,
                                       input logic [7:0] lk);
    return {d, c, b, a, ln, lk, lm};
  endfunction

  // Offer a job while idle, then scramble the inputs once it is accepted
  task automatic start_job(input logic [7:0] m, input logic [7:0] n, input logic [4:0] k,
                           input logic [9:0] ba, input logic [9:0] bb,
                           input logic [9:0] bc, input logic [9:0] bd,
                           input logic [9:0] sa, input logic [9:0] sb);
    check("job_ready_idle", 64'(job_ready), 64'd1);
    job_m = m; job_n = n; job_k = k;
    base_a = ba; base_b = bb; base_c = bc; base_d = bd;
    stride_a = sa; stride_b = sb;
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    job_m = 8'hFF; job_n = 8'hFF; job_k = 5'h1F;
    base_a = 10'h3FF; base_b = 10'h3FF; base_c = 10'h3FF; base_d = 10'h3FF;
    stride_a = 10'h3FF; stride_b = 10'h3FF;
  endtask

  task automatic wait_cmd(input string tag);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 64'(cmd_valid), 64'd1);
  endtask

  // Expects cmd_ready high: check the offered command and let it handshake
  task automatic collect(input string tag, input logic [63:0] exp);
    wait_cmd(tag);
    check(tag, cmd_data, exp);
    @(negedge clk);
  endtask

  task automatic pulse_done();
    tile_done = 1'b1;
    @(negedge clk);
    tile_done = 1'b0;
  endtask

  localparam logic [7:0] LM2 [2] = '{8'd16, 8'd4};
  localparam logic [7:0] LN3 [3] = '{8'd16, 8'd16, 8'd1};

  initial begin
    rst = 1'b1; job_valid = 1'b0; cmd_ready = 1'b1; tile_done = 1'b0;
    job_m = '0; job_n = '0; job_k = '0;
    base_a = '0; base_b = '0; base_c = '0; base_d = '0;
    stride_a = '0; stride_b = '0;
    repeat (2) @(negedge clk);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_cmd_data", cmd_data, 64'd0);
    check("rst_job_ready", 64'(job_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_job_done", 64'(job_done), 64'd0);
    check("rst_job_error", 64'(job_error), 64'd0);
    check("rst_tiles_issued", 64'(tiles_issued), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single 16x16x16 tile
    start_job(8'd16, 8'd16, 5'd16, 10'h000, 10'h100, 10'h200, 10'h300, 10'h000, 10'h000);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_ready_low", 64'(job_ready), 64'd0);
    collect("t1_cmd", pack(10'h000, 10'h100, 10'h200, 10'h300, 8'd16, 8'd16, 8'd16));
    check("t1_issued", 64'(tiles_issued), 64'd1);
    check("t1_no_done_yet", 64'(job_done), 64'd0);
    pulse_done();
    check("t1_job_done", 64'(job_done), 64'd1);
    check("t1_busy_idle", 64'(busy), 64'd0);
    check("t1_ready_idle", 64'(job_ready), 64'd1);
    @(negedge clk);
    check("t1_done_pulse", 64'(job_done), 64'd0);
    check("t1_issued_hold", 64'(tiles_issued), 64'd1);

    // 20x33x8: 2x3 tiles, ragged last row and column
    start_job(8'd20, 8'd33, 5'd8, 10'h040, 10'h0C0, 10'h200, 10'h300, 10'h010, 10'h020);
    check("t2_issued_clear", 64'(tiles_issued), 64'd0);
    for (int mi = 0; mi < 2; mi++) begin
      for (int ni = 0; ni < 3; ni++) begin
        collect($sformatf("t2_cmd%0d", mi * 3 + ni),
                pack(10'(10'h040 + mi * 'h10), 10'(10'h0C0 + ni * 'h20),
                     10'(10'h200 + ni * 16), 10'(10'h300 + (mi * 3 + ni) * 16),
                     LM2[mi], LN3[ni], 8'd8));
      end
    end
    check("t2_last_addr_d", 64'(cmd_data[63:54]), 64'h350);
    check("t2_last_addr_a", 64'(cmd_data[33:24]), 64'h050);
    check("t2_issued", 64'(tiles_issued), 64'd6);
    for (int i = 0; i < 6; i++) begin
      pulse_done();
      check($sformatf("t2_done_after%0d", i + 1), 64'(job_done), 64'(i == 5));
    end

    // Back-pressure: cmd_ready low for 10 cycles, completion during ISSUE
    cmd_ready = 1'b0;
    start_job(8'd32, 8'd16, 5'd4, 10'h010, 10'h020, 10'h030, 10'h040, 10'h008, 10'h004);
    wait_cmd("t3_first");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t3_hold_valid%0d", i), 64'(cmd_valid), 64'd1);
      check($sformatf("t3_hold_data%0d", i), cmd_data,
            pack(10'h010, 10'h020, 10'h030, 10'h040, 8'd16, 8'd16, 8'd4));
      tile_done = (i == 3);
      @(negedge clk);
    end
    tile_done = 1'b0;
    check("t3_issued_stall", 64'(tiles_issued), 64'd0);
    cmd_ready = 1'b1;
    @(negedge clk);
    check("t3_issued_one", 64'(tiles_issued), 64'd1);
    collect("t3_cmd1", pack(10'h018, 10'h020, 10'h030, 10'h050, 8'd16, 8'd16, 8'd4));
    check("t3_issued", 64'(tiles_issued), 64'd2);
    check("t3_busy_drain", 64'(busy), 64'd1);
    pulse_done();
    check("t3_job_done", 64'(job_done), 64'd1);

    // Illegal reduction depths and an empty matrix
    start_job(8'd16, 8'd16, 5'd0, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000);
    check("t4a_busy", 64'(busy), 64'd1);
    check("t4a_err_early", 64'(job_error), 64'd0);
    @(negedge clk);
    check("t4a_error", 64'(job_error), 64'd1);
    check("t4a_busy_low", 64'(busy), 64'd0);
    check("t4a_no_cmd", 64'(cmd_valid), 64'd0);
    @(negedge clk);
    check("t4a_err_pulse", 64'(job_error), 64'd0);
    start_job(8'd16, 8'd16, 5'd17, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000);
    @(negedge clk);
    check("t4b_error", 64'(job_error), 64'd1);
    check("t4b_busy_low", 64'(busy), 64'd0);
    check("t4b_no_cmd", 64'(cmd_valid), 64'd0);
    @(negedge clk);
    check("t4b_err_pulse", 64'(job_error), 64'd0);
    start_job(8'd0, 8'd16, 5'd4, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000);
    @(negedge clk);
    check("t4c_error", 64'(job_error), 64'd1);
    check("t4c_no_cmd", 64'(cmd_valid), 64'd0);
    @(negedge clk);

    // Reset in the middle of a 6-tile job
    start_job(8'd20, 8'd33, 5'd8, 10'h040, 10'h0C0, 10'h200, 10'h300, 10'h010, 10'h020);
    collect("t5_cmd0", pack(10'h040, 10'h0C0, 10'h200, 10'h300, 8'd16, 8'd16, 8'd8));
    collect("t5_cmd1", pack(10'h040, 10'h0E0, 10'h210, 10'h310, 8'd16, 8'd16, 8'd8));
    check("t5_issued2", 64'(tiles_issued), 64'd2);
    wait_cmd("t5_third");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_cmd_valid", 64'(cmd_valid), 64'd0);
    check("t5_cmd_data", cmd_data, 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_job_ready", 64'(job_ready), 64'd1);
    check("t5_issued", 64'(tiles_issued), 64'd0);
    pulse_done();
    check("t5_stray_done", 64'(job_done), 64'd0);
    check("t5_stray_busy", 64'(busy), 64'd0);
    start_job(8'd5, 8'd7, 5'd3, 10'h111, 10'h222, 10'h333, 10'h044, 10'h001, 10'h002);
    collect("t5_new_cmd", pack(10'h111, 10'h222, 10'h333, 10'h044, 8'd5, 8'd7, 8'd3));
    pulse_done();
    check("t5_new_done", 64'(job_done), 64'd1);
    check("t5_new_issued", 64'(tiles_issued), 64'd1);

    // Completions in IDLE and CHECK must not finish the next job
    repeat (3) pulse_done();
    check("t6_idle_done", 64'(job_done), 64'd0);
    start_job(8'd16, 8'd1, 5'd1, 10'h3F0, 10'h001, 10'h002, 10'h3F8, 10'h000, 10'h000);
    pulse_done();
    collect("t6_cmd", pack(10'h3F0, 10'h001, 10'h002, 10'h3F8, 8'd16, 8'd1, 8'd1));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t6_wait_done%0d", i), 64'(job_done), 64'd0);
      check($sformatf("t6_wait_busy%0d", i), 64'(busy), 64'd1);
      @(negedge clk);
    end
    pulse_done();
    check("t6_job_done", 64'(job_done), 64'd1);
    check("t6_busy_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
